// File: rtl/data_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the execute stage (A)
// and the debug/loader unit (B); one transaction in flight at a time.
module data_port_arbiter #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  // Port A: execute stage
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_stall,
  // Port B: debug/loader
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  // Memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam int unsigned CntW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(RD_LATENCY - 1);

  state_e state_q, state_d;

  logic              grant_b_q;  // granted port of the current transaction, 1 = B
  logic              last_b_q;   // port granted most recently, 1 = B
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  logic pick_a;
  logic pick_b;
  logic grant;
  logic capture;
  logic ack_any;

  // Contention goes to the port that did not win last time.
  always_comb begin
    pick_a  = a_req & (~b_req | last_b_q);
    pick_b  = b_req & ~pick_a;
    grant   = (state_q == StIdle) & (pick_a | pick_b);
    capture = (state_q == StWait) & (cnt_q == '0);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StIssue;
      StIssue: state_d = we_q ? StIdle : StWait;
      StWait:  if (cnt_q == '0) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered copy of the granted request and round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_b_q <= 1'b0;
      last_b_q  <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else if (grant) begin
      grant_b_q <= pick_b;
      last_b_q  <= pick_b;
      we_q      <= pick_b ? b_we    : a_we;
      addr_q    <= pick_b ? b_addr  : a_addr;
      wdata_q   <= pick_b ? b_wdata : a_wdata;
    end
  end

  // Read latency counter: reaches zero in the cycle mem_rdata is valid
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == StIssue) begin
      cnt_q <= CntLoad;
    end else if ((state_q == StWait) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Per-port read data; only the granted port's register is written
  always_ff @(posedge clock) begin
    if (reset) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else if (capture) begin
      if (grant_b_q) begin
        b_rdata_q <= mem_rdata;
      end else begin
        a_rdata_q <= mem_rdata;
      end
    end
  end

  // Output logic
  always_comb begin
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    ack_any = 1'b0;
    busy    = 1'b1;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StIssue: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        ack_any = we_q;
      end
      StWait:  ack_any = 1'b0;
      StResp:  ack_any = 1'b1;
      default: busy = 1'b0;
    endcase
    a_ack = ack_any & ~grant_b_q;
    b_ack = ack_any & grant_b_q;
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_stall   = a_req & ~a_ack;

  assert property (@(posedge clock) disable iff (reset) !(a_ack && b_ack));
  assert property (@(posedge clock) disable iff (reset) mem_en |=> !mem_en);

endmodule
